// File: rtl/audio_clk_gen.sv
// -----------------------------------------------------------------------------
// audio_clk_gen
//   Qualifies the audio PLL lock flag (2-flop synchroniser plus a stability
//   count), then derives WM8731 serial timing from the 18.432 MHz audio clock.
//   The outputs are the bit clock, the ADC/DAC LR clocks, and one-cycle strobes
//   for the serialiser. With the default parameters the bit clock is 3.072 MHz
//   and the LR clocks are 48 kHz.
//
// Optional feature macro: AUDIO_CLK_FRAME_CNT_EN
//   defined   -> frame_count counts frame starts. It wraps at 16 bits, holds
//                while idle and clears when the RUN state is left.
//   undefined -> frame_count is tied to 0 and no counter logic is built.
//
// Ports
//   clk            in   audio clock (PLL outclk_0)
//   reset_n        in   asynchronous active-low reset
//   pll_locked     in   PLL lock flag, asynchronous to clk
//   enable         in   request serial clock generation
//   lock_lost_clr  in   clears sticky lock_lost
//   ready          out  lock qualified (state RUN)
//   lock_lost      out  sticky: lock dropped while in RUN
//   aud_bclk       out  codec bit clock
//   aud_daclrck    out  DAC LR clock, 1 = left half
//   aud_adclrck    out  ADC LR clock, identical to aud_daclrck
//   bclk_rise      out  strobe on the first cycle aud_bclk reads 1
//   bclk_fall      out  strobe on the first cycle of each BCLK low phase
//   lr_edge        out  strobe on the first cycle after an LRCK change
//   frame_start    out  strobe on the first cycle of each frame
//   frame_count    out  frames started (see macro above)
// -----------------------------------------------------------------------------
module audio_clk_gen #(
  parameter int LOCK_CYCLES    = 1024,
  parameter int BCLK_DIV       = 6,
  parameter int BITS_PER_FRAME = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pll_locked,
  input  logic        enable,
  input  logic        lock_lost_clr,
  output logic        ready,
  output logic        lock_lost,
  output logic        aud_bclk,
  output logic        aud_daclrck,
  output logic        aud_adclrck,
  output logic        bclk_rise,
  output logic        bclk_fall,
  output logic        lr_edge,
  output logic        frame_start,
  output logic [15:0] frame_count
);

  localparam int LOCK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam int BCLK_W = $clog2(BCLK_DIV);
  localparam int BIT_W  = $clog2(BITS_PER_FRAME);

  localparam logic [LOCK_W-1:0] LOCK_MAX  = LOCK_W'(LOCK_CYCLES - 1);
  localparam logic [BCLK_W-1:0] BCLK_MAX  = BCLK_W'(BCLK_DIV - 1);
  localparam logic [BCLK_W-1:0] BCLK_HALF = BCLK_W'(BCLK_DIV / 2);
  localparam logic [BIT_W-1:0]  BIT_MAX   = BIT_W'(BITS_PER_FRAME - 1);
  localparam logic [BIT_W-1:0]  BIT_HALF  = BIT_W'(BITS_PER_FRAME / 2);

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_QUALIFY   = 2'd1,
    ST_RUN       = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Lock synchroniser
  // ---------------------------------------------------------------------------
  logic sync_meta_reg;
  logic locked_s_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_meta_reg <= 1'b0;
      locked_s_reg  <= 1'b0;
    end else begin
      sync_meta_reg <= pll_locked;
      locked_s_reg  <= sync_meta_reg;
    end
  end

  // ---------------------------------------------------------------------------
  // Lock qualification FSM: state register
  // ---------------------------------------------------------------------------
  state_t             state_reg, state_next;
  logic [LOCK_W-1:0]  lock_cnt_reg, lock_cnt_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= ST_WAIT_LOCK;
      lock_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      lock_cnt_reg <= lock_cnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Lock qualification FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    lock_cnt_next = '0;
    case (state_reg)
      ST_WAIT_LOCK: begin
        if (locked_s_reg) state_next = ST_QUALIFY;
      end
      ST_QUALIFY: begin
        if (!locked_s_reg) begin
          state_next = ST_WAIT_LOCK;
        end else if (lock_cnt_reg == LOCK_MAX) begin
          state_next = ST_RUN;
        end else begin
          lock_cnt_next = lock_cnt_reg + LOCK_W'(1);
        end
      end
      ST_RUN: begin
        if (!locked_s_reg) state_next = ST_WAIT_LOCK;
      end
      default: state_next = ST_WAIT_LOCK;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Lock qualification FSM: output logic and generator next state.
  // Every output is registered from the *next* counter values, so a
  // registered output always describes the counters it sits next to.
  // ---------------------------------------------------------------------------
  logic              run_next;
  logic              run_exit;
  logic              ready_reg, ready_next;
  logic              lock_lost_reg, lock_lost_next;
  logic              active_reg, active_next;
  logic [BCLK_W-1:0] bclk_cnt_reg, bclk_cnt_next;
  logic [BIT_W-1:0]  bit_cnt_reg, bit_cnt_next;
  logic              bclk_reg, bclk_next;
  logic              lrck_reg, lrck_next;
  logic              rise_reg, rise_next;
  logic              fall_reg, fall_next;
  logic              lr_edge_reg, lr_edge_next;
  logic              frame_start_reg, frame_start_next;

  always_comb begin
    run_next = (state_next == ST_RUN);
    run_exit = (state_reg == ST_RUN) && !run_next;

    ready_next = run_next;
    // Setting has priority over clearing so a loss is never missed.
    if (run_exit)           lock_lost_next = 1'b1;
    else if (lock_lost_clr) lock_lost_next = 1'b0;
    else                    lock_lost_next = lock_lost_reg;

    active_next   = active_reg;
    bclk_cnt_next = bclk_cnt_reg;
    bit_cnt_next  = bit_cnt_reg;
    if (!run_next) begin
      active_next   = 1'b0;
      bclk_cnt_next = '0;
      bit_cnt_next  = '0;
    end else if (!active_reg) begin
      // Counters are already zero while idle, so a start is always at a frame
      // boundary.
      if (ready_reg && enable) active_next = 1'b1;
    end else if (bclk_cnt_reg == BCLK_MAX) begin
      bclk_cnt_next = '0;
      if (bit_cnt_reg == BIT_MAX) begin
        bit_cnt_next = '0;
        // enable matters only here, so a frame is never cut short.
        active_next  = enable;
      end else begin
        bit_cnt_next = bit_cnt_reg + BIT_W'(1);
      end
    end else begin
      bclk_cnt_next = bclk_cnt_reg + BCLK_W'(1);
    end

    bclk_next        = active_next && (bclk_cnt_next >= BCLK_HALF);
    lrck_next        = active_next && (bit_cnt_next < BIT_HALF);
    fall_next        = active_next && (bclk_cnt_next == '0);
    rise_next        = active_next && (bclk_cnt_next == BCLK_HALF);
    lr_edge_next     = fall_next && ((bit_cnt_next == '0) || (bit_cnt_next == BIT_HALF));
    frame_start_next = fall_next && (bit_cnt_next == '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready_reg       <= 1'b0;
      lock_lost_reg   <= 1'b0;
      active_reg      <= 1'b0;
      bclk_cnt_reg    <= '0;
      bit_cnt_reg     <= '0;
      bclk_reg        <= 1'b0;
      lrck_reg        <= 1'b0;
      rise_reg        <= 1'b0;
      fall_reg        <= 1'b0;
      lr_edge_reg     <= 1'b0;
      frame_start_reg <= 1'b0;
    end else begin
      ready_reg       <= ready_next;
      lock_lost_reg   <= lock_lost_next;
      active_reg      <= active_next;
      bclk_cnt_reg    <= bclk_cnt_next;
      bit_cnt_reg     <= bit_cnt_next;
      bclk_reg        <= bclk_next;
      lrck_reg        <= lrck_next;
      rise_reg        <= rise_next;
      fall_reg        <= fall_next;
      lr_edge_reg     <= lr_edge_next;
      frame_start_reg <= frame_start_next;
    end
  end

  assign ready       = ready_reg;
  assign lock_lost   = lock_lost_reg;
  assign aud_bclk    = bclk_reg;
  assign aud_daclrck = lrck_reg;
  assign aud_adclrck = lrck_reg;
  assign bclk_rise   = rise_reg;
  assign bclk_fall   = fall_reg;
  assign lr_edge     = lr_edge_reg;
  assign frame_start = frame_start_reg;

  // ---------------------------------------------------------------------------
  // Optional frame counter
  // ---------------------------------------------------------------------------
`ifdef AUDIO_CLK_FRAME_CNT_EN
  logic [15:0] frame_count_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_count_reg <= 16'h0000;
    end else if (run_exit) begin
      frame_count_reg <= 16'h0000;
    end else if (frame_start_next) begin
      frame_count_reg <= frame_count_reg + 16'd1;
    end
  end

  assign frame_count = frame_count_reg;
`else
  assign frame_count = 16'h0000;
`endif

endmodule

// File: tb/tb_audio_clk_gen.sv
`timescale 1ns/1ps
module tb_audio_clk_gen;

  localparam int DIV       = 6;
  localparam int BITS      = 64;
  localparam int FRAME_CYC = DIV * BITS;   // 384
  localparam int READY_LAT = 1027;

`ifdef AUDIO_CLK_FRAME_CNT_EN
  localparam bit FC_EN = 1'b1;
`else
  localparam bit FC_EN = 1'b0;
`endif

  logic        clk    = 1'b0;
  logic        clk_en = 1'b1;
  logic        reset_n;
  logic        pll_locked;
  logic        enable;
  logic        lock_lost_clr;
  logic        ready;
  logic        lock_lost;
  logic        aud_bclk;
  logic        aud_daclrck;
  logic        aud_adclrck;
  logic        bclk_rise;
  logic        bclk_fall;
  logic        lr_edge;
  logic        frame_start;
  logic [15:0] frame_count;

  int checks   = 0;
  int failures = 0;

  // Scoreboards: expected generator outputs per edge, expected ready latency.
  logic [6:0] gen_q[$];
  int         lat_q[$];

  logic [6:0] gen_obs;
  assign gen_obs = {aud_bclk, aud_daclrck, aud_adclrck, bclk_rise, bclk_fall, lr_edge, frame_start};

  audio_clk_gen dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .pll_locked   (pll_locked),
    .enable       (enable),
    .lock_lost_clr(lock_lost_clr),
    .ready        (ready),
    .lock_lost    (lock_lost),
    .aud_bclk     (aud_bclk),
    .aud_daclrck  (aud_daclrck),
    .aud_adclrck  (aud_adclrck),
    .bclk_rise    (bclk_rise),
    .bclk_fall    (bclk_fall),
    .lr_edge      (lr_edge),
    .frame_start  (frame_start),
    .frame_count  (frame_count)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  // Expected waveform t cycles after the generator starts, derived from time.
  function automatic logic [6:0] exp_active(int t);
    int  pb = t % DIV;
    int  pf = t % FRAME_CYC;
    logic l = (pf < FRAME_CYC / 2);
    return {(pb >= DIV / 2), l, l, (pb == DIV / 2), (pb == 0),
            ((t % (FRAME_CYC / 2)) == 0), (pf == 0)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Edges until ready is first seen high; -1 if the bound expires.
  task automatic measure_ready(output int edges);
    edges = -1;
    for (int n = 1; n <= 2000 && edges < 0; n++) begin
      step();
      if (ready === 1'b1) edges = n;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; pll_locked = 1'b0; enable = 1'b0; lock_lost_clr = 1'b0;
    #23;
    checks++;
    if ({ready, lock_lost, gen_obs} !== 9'h000) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=%b", {ready, lock_lost, gen_obs}, 9'h000);
    end
    checks++;
    if (frame_count !== 16'h0000) begin
      failures++;
      $display("FAIL reset_frame_count got=%h exp=0000", frame_count);
    end
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (ready !== 1'b0) begin
      failures++;
      $display("FAIL unlocked_ready got=%b exp=0", ready);
    end
  endtask

  task automatic test_lock_qualify();
    int e, exp_e;
    pll_locked = 1'b1;
    lat_q.push_back(READY_LAT);
    measure_ready(e);
    exp_e = lat_q.pop_front();
    checks++;
    if (e !== exp_e) begin
      failures++;
      $display("FAIL lock_qualify_latency got=%0d exp=%0d", e, exp_e);
    end
    checks++;
    if (lock_lost !== 1'b0) begin
      failures++;
      $display("FAIL lock_qualify_lock_lost got=%b exp=0", lock_lost);
    end
  endtask

  task automatic test_glitch();
    int e, exp_e;
    bit early;
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    pll_locked = 1'b1;
    early = 1'b0;
    for (int i = 0; i < 502; i++) begin
      step();
      if (ready !== 1'b0) early = 1'b1;
    end
    pll_locked = 1'b0;
    step();
    if (ready !== 1'b0) early = 1'b1;
    pll_locked = 1'b1;
    checks++;
    if (early) begin
      failures++;
      $display("FAIL glitch_early_ready got=1 exp=0");
    end
    lat_q.push_back(READY_LAT);
    measure_ready(e);
    exp_e = lat_q.pop_front();
    checks++;
    if (e !== exp_e) begin
      failures++;
      $display("FAIL glitch_latency got=%0d exp=%0d", e, exp_e);
    end
  endtask

  task automatic test_run_clocks();
    logic [6:0] exp_v;
    enable = 1'b1;
    for (int t = 0; t < 800; t++) begin
      gen_q.push_back(exp_active(t));
      step();
      exp_v = gen_q.pop_front();
      checks++;
      if (gen_obs !== exp_v) begin
        failures++;
        $display("FAIL run_clocks t=%0d got=%b exp=%b", t, gen_obs, exp_v);
      end
    end
    checks++;
    if (frame_count !== (FC_EN ? 16'd3 : 16'd0)) begin
      failures++;
      $display("FAIL run_frame_count got=%0d exp=%0d", frame_count, FC_EN ? 3 : 0);
    end
  endtask

  task automatic test_enable_drop();
    logic [6:0] exp_v;
    // Continue the running frame; drop enable at bit 20 of the third frame.
    for (int t = 800; t < 3 * FRAME_CYC; t++) begin
      if (t == 2 * FRAME_CYC + 20 * DIV) enable = 1'b0;
      gen_q.push_back(exp_active(t));
      step();
      exp_v = gen_q.pop_front();
      checks++;
      if (gen_obs !== exp_v) begin
        failures++;
        $display("FAIL drop_finish_frame t=%0d got=%b exp=%b", t, gen_obs, exp_v);
      end
    end
    for (int k = 0; k < 400; k++) begin
      gen_q.push_back(7'b0);
      step();
      exp_v = gen_q.pop_front();
      checks++;
      if (gen_obs !== exp_v) begin
        failures++;
        $display("FAIL drop_idle k=%0d got=%b exp=%b", k, gen_obs, exp_v);
      end
    end
    checks++;
    if (frame_count !== (FC_EN ? 16'd3 : 16'd0)) begin
      failures++;
      $display("FAIL idle_frame_count got=%0d exp=%0d", frame_count, FC_EN ? 3 : 0);
    end
    enable = 1'b1;
    for (int t = 0; t < 400; t++) begin
      gen_q.push_back(exp_active(t));
      step();
      exp_v = gen_q.pop_front();
      checks++;
      if (gen_obs !== exp_v) begin
        failures++;
        $display("FAIL drop_restart t=%0d got=%b exp=%b", t, gen_obs, exp_v);
      end
    end
  endtask

  task automatic test_lock_loss();
    logic [6:0] exp_v;
    int e;
    pll_locked = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      gen_q.push_back((k < 3) ? exp_active(399 + k) : 7'b0);
      step();
      exp_v = gen_q.pop_front();
      checks++;
      if ({ready, gen_obs} !== {(k < 3), exp_v}) begin
        failures++;
        $display("FAIL loss_edge%0d got=%b exp=%b", k, {ready, gen_obs}, {(k < 3), exp_v});
      end
    end
    checks++;
    if (lock_lost !== 1'b1) begin
      failures++;
      $display("FAIL loss_lock_lost got=%b exp=1", lock_lost);
    end
    checks++;
    if (frame_count !== 16'h0000) begin
      failures++;
      $display("FAIL loss_frame_count got=%0d exp=0", frame_count);
    end
    lock_lost_clr = 1'b1;
    step();
    lock_lost_clr = 1'b0;
    step();
    checks++;
    if (lock_lost !== 1'b0) begin
      failures++;
      $display("FAIL lone_clear got=%b exp=0", lock_lost);
    end
    // Re-lock, then lose lock again with the clear landing on the set edge.
    pll_locked = 1'b1;
    measure_ready(e);
    checks++;
    if (e !== READY_LAT) begin
      failures++;
      $display("FAIL relock_latency got=%0d exp=%0d", e, READY_LAT);
    end
    pll_locked = 1'b0;
    step();
    step();
    lock_lost_clr = 1'b1;
    step();
    lock_lost_clr = 1'b0;
    checks++;
    if ({ready, lock_lost} !== 2'b01) begin
      failures++;
      $display("FAIL set_beats_clear got=%b exp=01", {ready, lock_lost});
    end
    lock_lost_clr = 1'b1;
    step();
    lock_lost_clr = 1'b0;
    checks++;
    if (lock_lost !== 1'b0) begin
      failures++;
      $display("FAIL second_clear got=%b exp=0", lock_lost);
    end
  endtask

  task automatic test_reset_midframe();
    logic [6:0] exp_v;
    int e;
    pll_locked = 1'b1;
    measure_ready(e);
    checks++;
    if (e !== READY_LAT) begin
      failures++;
      $display("FAIL midframe_lock_latency got=%0d exp=%0d", e, READY_LAT);
    end
    for (int t = 0; t <= 2 * FRAME_CYC + 100; t++) begin
      gen_q.push_back(exp_active(t));
      step();
      exp_v = gen_q.pop_front();
      checks++;
      if (gen_obs !== exp_v) begin
        failures++;
        $display("FAIL midframe_run t=%0d got=%b exp=%b", t, gen_obs, exp_v);
      end
    end
    checks++;
    if (frame_count !== (FC_EN ? 16'd3 : 16'd0)) begin
      failures++;
      $display("FAIL three_frames_count got=%0d exp=%0d", frame_count, FC_EN ? 3 : 0);
    end
    // Freeze the clock, then reset: outputs must clear with no edge.
    clk_en = 1'b0;
    #3;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({ready, lock_lost, gen_obs, frame_count} !== 25'h0) begin
      failures++;
      $display("FAIL midframe_async_reset got=%b exp=0", {ready, lock_lost, gen_obs, frame_count});
    end
    #10;
    clk_en = 1'b1;
    reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_lock_qualify();
    test_glitch();
    test_run_clocks();
    test_enable_drop();
    test_lock_loss();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
